tlk2711_tx_framer: RTL
======================

// Module: tlk2711_tx_framer
// PURPOSE
//  Downstream of the TX command stage. Consumes the DMA MM2S read stream (64-bit AXI-Stream) plus the latched
//  packet_body/packet_tail/send_start controls, and emits 16-bit TLK2711 transmit words with K-char control.
//  Frame on the wire: SOF, 2 header words, body, tail fill, checksum, EOF. K28.5 idle is sent between frames.
// PARAMETERS
//  DATA_W     64       input stream width; fixed at 4x16 (other values unsupported)
//  IDLE_WORD  16'hC5BC K28.5 idle word; LSB is K-char
//  FILL_WORD  16'h0000 tail fill word value
// PORTS
//  i_clk             in   1   clock
//  i_rst_n           in   1   asynchronous reset, active low
//  i_soft_rst        in   1   synchronous soft reset, active high
//  i_send_start      in   1   1-cycle start pulse
//  i_packet_body     in   22  body length in 64-bit beats
//  i_packet_tail     in   10  number of FILL_WORD words after body
//  i_axis_tdata      in   64  DMA read data; least-significant 16 bits first on the wire
//  i_axis_tvalid     in   1   beat valid
//  i_axis_tlast      in   1   last beat of DMA transfer
//  o_axis_tready     out  1   beat accepted when tvalid&tready
//  o_tlk_txd         out  16  TLK2711 TXD
//  o_tlk_tkmsb       out  1   TXD[15:8] is K-char
//  o_tlk_tklsb       out  1   TXD[7:0] is K-char
//  o_busy            out  1   high from start accept until EOF sent
//  o_frame_done      out  1   1-cycle pulse, same cycle EOF is on o_tlk_txd
//  o_frame_cnt       out  16  frames completed; wraps 0xFFFF->0
//  o_underrun        out  1   sticky: idle word inserted mid-body
//  o_len_err         out  1   sticky: tlast on a beat other than the last body beat
//  o_start_ignored   out  1   1-cycle pulse: start while busy
// BEHAVIOUR
//  Reset (async or soft): state IDLE; o_tlk_txd=IDLE_WORD, tklsb=1, tkmsb=0; tready=0; all flags, counters and
//   checksum = 0. Soft reset mid-frame aborts the frame (no EOF) and takes effect on the next edge.
//  FSM: IDLE->SOF->HDR0->HDR1->BODY->TAIL->CSUM->EOF->IDLE.
//   BODY is skipped if body==0; TAIL is skipped if tail==0.
//  Start sampled at edge N: lengths latched, state=SOF at N. SOF word is on o_tlk_txd after edge N+1.
//   All TLK outputs are registered.
//  SOF = 16'h50FB (K27.7 in LSB, tklsb=1). EOF = 16'h50FD (K29.7 in LSB, tklsb=1).
//   HDR0 = frame_cnt. HDR1 = body[15:0].
//   CSUM = 16-bit sum, mod 2^16, of HDR0, HDR1, all body words and all fill words. Data words have tk*=0.
//  BODY: 64-bit hold register plus word index 0..3. tready=1 in BODY only when the hold reg is empty or its
//   word 3 is being sent this cycle (zero-bubble at full rate). One beat gives 4 consecutive words.
//   Beat counter counts down from body.
//  Underrun: in BODY, if no word is available, send IDLE_WORD (tklsb=1) and set o_underrun. The word index does
//   not advance, and the checksum does not include the idle word.
//  tlast check: tlast=1 on an accepted beat != last → o_len_err set. The framer still sends exactly body beats.
//   Missing tlast on the last beat also sets o_len_err.
//  No beats are accepted outside BODY (tready=0). Leftover DMA data is left to the upstream stage to flush.
//  TAIL: tail words of FILL_WORD, one per cycle.
//  EOF cycle: o_frame_done=1; frame_cnt increments; busy drops the following cycle; next start is accepted then.
//  Start while busy: ignored, o_start_ignored pulses; latched lengths are unchanged.
//  Sticky flags are cleared only by reset or soft reset.
// STRUCTURE
//  tlk2711_pkg: K-char constants (K28.5, K27.7, K29.7, 8'h50 pad), tx_state_e enum, DATA_W.
//  Sub-module tlk2711_tx_gearbox: 64->16 serializer (hold reg, word index, tready generation, word_valid).
//  The framer FSM, checksum and counters live in this module.
// TESTING
//  body=2, tail=3, stream always valid with tlast on beat 2 -> SOF, HDR0=0, HDR1=2, 8 data words LSW-first,
//   3x0000, CSUM, EOF; frame_cnt=1.
//  body=0, tail=0 -> SOF, 0000, 0000, CSUM=0000, EOF; o_frame_done one pulse; no tready.
//  body=3, tvalid low for 5 cycles before beat 2 -> 5 idle words mid-body with tklsb=1; o_underrun=1;
//   CSUM equals the no-gap value.
//  body=4, tlast on beat 2 -> o_len_err=1; 16 body words still sent, then EOF.
//  Start pulse during BODY -> o_start_ignored 1 cycle; frame unaffected.
//   Soft reset during BODY -> next cycle idle word, tready=0, busy=0.
//  Preload frame_cnt 0xFFFF by back-to-back frames (force), complete one -> HDR0=FFFF, frame_cnt=0000.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared constants and state type for the TLK2711 transmit path.
package tlk2711_pkg;

   localparam int unsigned TX_DATA_W = 64;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K_PAD = 8'h50;

   localparam logic [15:0] SOF_WORD = {K_PAD, K27_7};
   localparam logic [15:0] EOF_WORD = {K_PAD, K29_7};

   typedef enum logic [2:0] {
      StIdle,
      StSof,
      StHdr0,
      StHdr1,
      StBody,
      StTail,
      StCsum,
      StEof
   } tx_state_e;

endpackage

// File: rtl/tlk2711_tx_gearbox.sv
// 64->16 serializer: one held beat is sent as four words, least-significant first.
module tlk2711_tx_gearbox
   import tlk2711_pkg::*;
#(
   parameter int unsigned DATA_W = TX_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic              i_adv,
   input  logic [DATA_W-1:0] i_tdata,
   input  logic              i_tvalid,
   output logic              o_tready,
   output logic              o_load,
   output logic              o_word_valid,
   output logic [15:0]       o_word,
   output logic              o_word_last
);

   logic [DATA_W-1:0] hold_q, hold_d;
   logic              full_q, full_d;
   logic [1:0]        idx_q, idx_d;
   logic [15:0]       hold_word;

   always_comb begin
      hold_word = hold_q[15:0];
      unique case (idx_q)
         2'd0: hold_word = hold_q[15:0];
         2'd1: hold_word = hold_q[31:16];
         2'd2: hold_word = hold_q[47:32];
         2'd3: hold_word = hold_q[63:48];
      endcase
   end

   assign o_tready     = i_en & (~full_q | (i_adv & (idx_q == 2'd3)));
   assign o_load       = o_tready & i_tvalid;
   // An empty hold reg forwards word 0 of the incoming beat, so BODY starts without a bubble.
   assign o_word_valid = full_q | o_load;
   assign o_word       = full_q ? hold_word : i_tdata[15:0];
   assign o_word_last  = full_q & (idx_q == 2'd3);

   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      idx_d  = idx_q;
      if (i_adv && o_word_valid) begin
         if (o_load) begin
            hold_d = i_tdata;
            full_d = 1'b1;
            idx_d  = full_q ? 2'd0 : 2'd1;
         end else if (idx_q == 2'd3) begin
            full_d = 1'b0;
            idx_d  = 2'd0;
         end else begin
            idx_d = idx_q + 2'd1;
         end
      end else if (o_load) begin
         hold_d = i_tdata;
         full_d = 1'b1;
         idx_d  = 2'd0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_q <= '0;
         full_q <= 1'b0;
         idx_q  <= 2'd0;
      end else if (i_clr) begin
         hold_q <= '0;
         full_q <= 1'b0;
         idx_q  <= 2'd0;
      end else begin
         hold_q <= hold_d;
         full_q <= full_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: SOF, header, DMA body, tail fill, checksum, EOF, with K28.5 idle between.
module tlk2711_tx_framer
   import tlk2711_pkg::*;
#(
   parameter int unsigned DATA_W    = TX_DATA_W,
   parameter logic [15:0] IDLE_WORD = {8'hC5, K28_5},
   parameter logic [15:0] FILL_WORD = 16'h0000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_soft_rst,
   input  logic              i_send_start,
   input  logic [21:0]       i_packet_body,
   input  logic [9:0]        i_packet_tail,
   input  logic [DATA_W-1:0] i_axis_tdata,
   input  logic              i_axis_tvalid,
   input  logic              i_axis_tlast,
   output logic              o_axis_tready,
   output logic [15:0]       o_tlk_txd,
   output logic              o_tlk_tkmsb,
   output logic              o_tlk_tklsb,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic [15:0]       o_frame_cnt,
   output logic              o_underrun,
   output logic              o_len_err,
   output logic              o_start_ignored
);

   tx_state_e   state_q, state_d;
   logic [21:0] acc_left_q, acc_left_d;
   logic [9:0]  tail_left_q, tail_left_d;
   logic [15:0] csum_q, csum_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        busy_q, busy_d;
   logic [15:0] txd_q, txd_d;
   logic        tkmsb_q, tkmsb_d;
   logic        tklsb_q, tklsb_d;
   logic        frame_done_q, frame_done_d;
   logic        underrun_q, underrun_d;
   logic        len_err_q, len_err_d;
   logic        start_ign_q, start_ign_d;

   logic        in_body;
   logic        gb_tready, gb_load, gb_word_valid, gb_word_last;
   logic [15:0] gb_word;

   assign in_body = (state_q == StBody);

   tlk2711_tx_gearbox #(
      .DATA_W (DATA_W)
   ) u_gearbox (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (i_soft_rst),
      .i_en         (in_body & (acc_left_q != 22'd0)),
      .i_adv        (in_body),
      .i_tdata      (i_axis_tdata),
      .i_tvalid     (i_axis_tvalid),
      .o_tready     (gb_tready),
      .o_load       (gb_load),
      .o_word_valid (gb_word_valid),
      .o_word       (gb_word),
      .o_word_last  (gb_word_last)
   );

   always_comb begin
      state_d      = state_q;
      acc_left_d   = acc_left_q;
      tail_left_d  = tail_left_q;
      csum_d       = csum_q;
      frame_cnt_d  = frame_cnt_q;
      busy_d       = busy_q;
      underrun_d   = underrun_q;
      len_err_d    = len_err_q;
      txd_d        = IDLE_WORD;
      tkmsb_d      = 1'b0;
      tklsb_d      = 1'b1;
      frame_done_d = 1'b0;
      start_ign_d  = i_send_start & busy_q;

      if (frame_done_q) begin
         busy_d = 1'b0;
      end

      if (gb_load) begin
         acc_left_d = acc_left_q - 22'd1;
         if (i_axis_tlast != (acc_left_q == 22'd1)) begin
            len_err_d = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (i_send_start && !busy_q) begin
               acc_left_d  = i_packet_body;
               tail_left_d = i_packet_tail;
               csum_d      = 16'h0000;
               busy_d      = 1'b1;
               state_d     = StSof;
            end
         end
         StSof: begin
            txd_d   = SOF_WORD;
            state_d = StHdr0;
         end
         StHdr0: begin
            txd_d   = frame_cnt_q;
            tklsb_d = 1'b0;
            csum_d  = csum_q + frame_cnt_q;
            state_d = StHdr1;
         end
         StHdr1: begin
            txd_d   = acc_left_q[15:0];
            tklsb_d = 1'b0;
            csum_d  = csum_q + acc_left_q[15:0];
            if (acc_left_q != 22'd0) begin
               state_d = StBody;
            end else if (tail_left_q != 10'd0) begin
               state_d = StTail;
            end else begin
               state_d = StCsum;
            end
         end
         StBody: begin
            if (gb_word_valid) begin
               txd_d   = gb_word;
               tklsb_d = 1'b0;
               csum_d  = csum_q + gb_word;
               // Final word: word 3 of a beat with nothing left to accept.
               if (gb_word_last && acc_left_q == 22'd0) begin
                  state_d = (tail_left_q != 10'd0) ? StTail : StCsum;
               end
            end else begin
               underrun_d = 1'b1;
            end
         end
         StTail: begin
            txd_d       = FILL_WORD;
            tklsb_d     = 1'b0;
            csum_d      = csum_q + FILL_WORD;
            tail_left_d = tail_left_q - 10'd1;
            if (tail_left_q == 10'd1) begin
               state_d = StCsum;
            end
         end
         StCsum: begin
            txd_d   = csum_q;
            tklsb_d = 1'b0;
            state_d = StEof;
         end
         StEof: begin
            txd_d        = EOF_WORD;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         acc_left_q   <= '0;
         tail_left_q  <= '0;
         csum_q       <= '0;
         frame_cnt_q  <= '0;
         busy_q       <= 1'b0;
         txd_q        <= IDLE_WORD;
         tkmsb_q      <= 1'b0;
         tklsb_q      <= 1'b1;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
         len_err_q    <= 1'b0;
         start_ign_q  <= 1'b0;
      end else if (i_soft_rst) begin
         state_q      <= StIdle;
         acc_left_q   <= '0;
         tail_left_q  <= '0;
         csum_q       <= '0;
         frame_cnt_q  <= '0;
         busy_q       <= 1'b0;
         txd_q        <= IDLE_WORD;
         tkmsb_q      <= 1'b0;
         tklsb_q      <= 1'b1;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
         len_err_q    <= 1'b0;
         start_ign_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_left_q   <= acc_left_d;
         tail_left_q  <= tail_left_d;
         csum_q       <= csum_d;
         frame_cnt_q  <= frame_cnt_d;
         busy_q       <= busy_d;
         txd_q        <= txd_d;
         tkmsb_q      <= tkmsb_d;
         tklsb_q      <= tklsb_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
         len_err_q    <= len_err_d;
         start_ign_q  <= start_ign_d;
      end
   end

   assign o_axis_tready   = gb_tready;
   assign o_tlk_txd       = txd_q;
   assign o_tlk_tkmsb     = tkmsb_q;
   assign o_tlk_tklsb     = tklsb_q;
   assign o_busy          = busy_q;
   assign o_frame_done    = frame_done_q;
   assign o_frame_cnt     = frame_cnt_q;
   assign o_underrun      = underrun_q;
   assign o_len_err       = len_err_q;
   assign o_start_ignored = start_ign_q;

endmodule
